// File: rtl/pll_lock_reset_seq.sv
// Synchronizes and qualifies the PLL lock flag, then drives the system reset/ready pair.
// A lock loss in RUN forces a minimum reset hold and bumps a saturating loss counter.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked_async,
  output logic             sys_reset,
  output logic             sys_ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOSS      = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [CW-1:0]      cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               lost_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign state  = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      sys_reset  <= 1'b1;
      sys_ready  <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], locked_async};
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      // Outputs follow next-state so they move on the same edge as state.
      sys_reset  <= (state_nxt != RUN);
      sys_ready  <= (state_nxt == RUN);
      lock_lost  <= lost_nxt;
      loss_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    lost_nxt  = 1'b0;
    count_nxt = loss_count;
    case (state_q)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = LOSS;
          lost_nxt  = 1'b1;
          if (loss_count != '1) count_nxt = loss_count + 1'b1;
        end
      end
      LOSS: begin
        // lock_s is deliberately ignored until the hold time has elapsed.
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench: stimulus queues expected output snapshots keyed by clock edge;
// the monitor checks every output change and every queued snapshot.
module tb_pll_lock_reset_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked_async;
  logic       sys_reset, sys_ready, lock_lost;
  logic [1:0] loss_count;
  logic [1:0] state;

  pll_lock_reset_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4), .CNT_W(2)
  ) dut (
    .clock(clock), .reset(reset), .locked_async(locked_async),
    .sys_reset(sys_reset), .sys_ready(sys_ready), .lock_lost(lock_lost),
    .loss_count(loss_count), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [6:0] v;   // {state, sys_reset, sys_ready, lock_lost, loss_count}
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 0;
  logic [6:0] prev, cur;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected snapshot after edge c; reset/ready derive from the expected state.
  task automatic expect_at(input int c, input logic [1:0] st, input logic ll, input logic [1:0] lc);
    exp_t e;
    e.cyc = c;
    e.v   = {st, (st != 2'd2), (st == 2'd2), ll, lc};
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    cur = {state, sys_reset, sys_ready, lock_lost, loss_count};
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_event cyc=%0d expected=%b never checked", q[0].cyc, q[0].v);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (cur !== e.v) begin
          bad++;
          $display("FAIL snapshot cyc=%0d got st=%0d rst=%b rdy=%b ll=%b lc=%0d want st=%0d rst=%b rdy=%b ll=%b lc=%0d",
                   cyc, cur[6:5], cur[4], cur[3], cur[2], cur[1:0],
                   e.v[6:5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
        end
      end else if (cur !== prev) begin
        total++; bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, cur, prev);
      end
    end
    prev = cur;
  end

  // One lock-loss episode from RUN, lock back high one cycle later.
  // Loss seen 2 edges after sampling, 4-cycle hold, 1 edge to STABLE, 8 to RUN.
  task automatic loss_cycle(input logic [1:0] lc);
    int c;
    c = cyc;
    locked_async = 1'b0;
    expect_at(c + 3,  2'd3, 1'b1, lc);
    expect_at(c + 4,  2'd3, 1'b0, lc);
    expect_at(c + 6,  2'd3, 1'b0, lc);
    expect_at(c + 7,  2'd0, 1'b0, lc);
    expect_at(c + 8,  2'd1, 1'b0, lc);
    expect_at(c + 16, 2'd2, 1'b0, lc);
    tick(1);
    locked_async = 1'b1;
    tick(17);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    locked_async = 1'b0;
    tick(3);
    mon_en = 1'b1;

    // Reset state and 100 cycles with lock held low.
    c = cyc;
    expect_at(c + 1, 2'd0, 1'b0, 2'd0);
    reset = 1'b0;
    for (int k = 25; k <= 100; k += 25) expect_at(c + k, 2'd0, 1'b0, 2'd0);
    tick(100);

    // Lock rises: sampled at edge c+1, STABLE two edges later, RUN after 8 more.
    c = cyc;
    locked_async = 1'b1;
    expect_at(c + 3,  2'd1, 1'b0, 2'd0);
    expect_at(c + 11, 2'd2, 1'b0, 2'd0);
    tick(13);

    // First loss, lock returns during the hold.
    loss_cycle(2'd1);

    // Second loss, then a one-cycle glitch seen while STABLE with cnt=5.
    c = cyc;
    locked_async = 1'b0;
    expect_at(c + 3,  2'd3, 1'b1, 2'd2);
    expect_at(c + 4,  2'd3, 1'b0, 2'd2);
    expect_at(c + 7,  2'd0, 1'b0, 2'd2);
    expect_at(c + 8,  2'd1, 1'b0, 2'd2);
    expect_at(c + 14, 2'd0, 1'b0, 2'd2);
    expect_at(c + 15, 2'd1, 1'b0, 2'd2);
    expect_at(c + 22, 2'd1, 1'b0, 2'd2);
    expect_at(c + 23, 2'd2, 1'b0, 2'd2);
    tick(1);
    locked_async = 1'b1;
    tick(10);
    locked_async = 1'b0;
    tick(1);
    locked_async = 1'b1;
    tick(13);

    // Reset while in RUN with loss_count=2 clears everything, incl. the sync chain.
    c = cyc;
    reset = 1'b1;
    expect_at(c + 1,  2'd0, 1'b0, 2'd0);
    expect_at(c + 3,  2'd0, 1'b0, 2'd0);
    expect_at(c + 4,  2'd1, 1'b0, 2'd0);
    expect_at(c + 11, 2'd1, 1'b0, 2'd0);
    expect_at(c + 12, 2'd2, 1'b0, 2'd0);
    tick(1);
    reset = 1'b0;
    tick(13);

    // Four losses: count saturates at 3, pulse still fires every time.
    loss_cycle(2'd1);
    loss_cycle(2'd2);
    loss_cycle(2'd3);
    loss_cycle(2'd3);

    tick(5);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
